// File: rtl/mips_pkg.sv
// Shared encodings for the load/store unit: access ops, FSM states, lane offsets.
package mips_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Big-endian lanes: offset 0 is the most significant byte / halfword.
  localparam logic [1:0] BYTE_OFF0 = 2'd0;
  localparam logic [1:0] BYTE_OFF1 = 2'd1;
  localparam logic [1:0] BYTE_OFF2 = 2'd2;
  localparam logic [1:0] BYTE_OFF3 = 2'd3;
  localparam logic [1:0] HALF_OFF0 = 2'd0;
  localparam logic [1:0] HALF_OFF2 = 2'd2;

  function automatic logic is_load(input op_t op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
  endfunction

  function automatic logic misaligned(input op_t op, input logic [1:0] off);
    case (op)
      OP_LW, OP_SW:        return off != 2'd0;
      OP_LH, OP_LHU, OP_SH: return off[0];
      default:             return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: extract/extend load data and merge sub-word store data
// into the previously read word. No state, no handshake.
module mem_lane_align
  import mips_pkg::*;
(
  input  logic [1:0]  i_off,
  input  op_t         i_op,
  input  logic [31:0] i_word,
  input  logic [15:0] i_sdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_wdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_off)
      BYTE_OFF0: w_byte = i_word[31:24];
      BYTE_OFF1: w_byte = i_word[23:16];
      BYTE_OFF2: w_byte = i_word[15:8];
      default:   w_byte = i_word[7:0];
    endcase
  end

  assign w_half = (i_off == HALF_OFF2) ? i_word[15:0] : i_word[31:16];

  always_comb begin
    case (i_op)
      OP_LB:   o_rdata = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  o_rdata = {24'h0, w_byte};
      OP_LH:   o_rdata = {{16{w_half[15]}}, w_half};
      OP_LHU:  o_rdata = {16'h0, w_half};
      OP_LW:   o_rdata = i_word;
      default: o_rdata = 32'h0;
    endcase
  end

  always_comb begin
    o_wdata = i_word;
    if (i_op == OP_SB) begin
      case (i_off)
        BYTE_OFF0: o_wdata[31:24] = i_sdata[7:0];
        BYTE_OFF1: o_wdata[23:16] = i_sdata[7:0];
        BYTE_OFF2: o_wdata[15:8]  = i_sdata[7:0];
        BYTE_OFF3: o_wdata[7:0]   = i_sdata[7:0];
        default:   o_wdata = i_word;
      endcase
    end else if (i_op == OP_SH) begin
      if (i_off == HALF_OFF0) o_wdata[31:16] = i_sdata;
      else                    o_wdata[15:0]  = i_sdata;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator; resp after 1 (error), 2 (load/SW), 3 (SB/SH RMW) cycles.
// req_ready only in IDLE; response held stable until resp_ready.
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [31:0]       mem_rdata
);

  state_t              r_state;
  op_t                 r_op;
  logic [1:0]          r_off;
  logic [15:0]         r_sdata;
  logic                r_req_ready;
  logic                r_resp_valid;
  logic                r_resp_err;
  logic [31:0]         r_resp_rdata;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_mem_rd;
  logic                r_mem_wr;

  op_t                 w_op;
  logic                w_mis;
  logic [ADDR_W-1:0]   w_word_addr;
  logic [31:0]         w_ld_data;
  logic [31:0]         w_st_word;

  assign w_op        = op_t'(req_op);
  assign w_mis       = misaligned(w_op, req_addr[1:0]);
  assign w_word_addr = {req_addr[ADDR_W-1:2], 2'b00};

  // mem_rdata is only valid during the RD strobe; both results are registered on that edge.
  mem_lane_align u_align (
    .i_off   (r_off),
    .i_op    (r_op),
    .i_word  (mem_rdata),
    .i_sdata (r_sdata),
    .o_rdata (w_ld_data),
    .o_wdata (w_st_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_op         <= OP_LB;
      r_off        <= 2'd0;
      r_sdata      <= 16'h0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'h0;
      r_mem_rd     <= 1'b0;
      r_mem_wr     <= 1'b0;
    end else begin
      r_mem_rd <= 1'b0;
      r_mem_wr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_op        <= w_op;
            r_off       <= req_addr[1:0];
            r_sdata     <= req_wdata[15:0];
            r_req_ready <= 1'b0;
            if (w_mis) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'h0;
            end else if (w_op == OP_SW) begin
              r_state     <= ST_WR;
              r_mem_wr    <= 1'b1;
              r_mem_addr  <= w_word_addr;
              r_mem_wdata <= req_wdata;
            end else begin
              r_state    <= ST_RD;
              r_mem_rd   <= 1'b1;
              r_mem_addr <= w_word_addr;
            end
          end
        end
        ST_RD: begin
          if (is_load(r_op)) begin
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= w_ld_data;
          end else begin
            r_state     <= ST_WR;
            r_mem_wr    <= 1'b1;
            r_mem_wdata <= w_st_word;
          end
        end
        ST_WR: begin
          r_state      <= ST_RESP;
          r_resp_valid <= 1'b1;
          r_resp_err   <= 1'b0;
          r_resp_rdata <= 32'h0;
        end
        ST_RESP: begin
          if (resp_ready) begin
            r_state      <= ST_IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_rd     = r_mem_rd;
  assign mem_wr     = r_mem_wr;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboarded bench for mem_access_unit against a small level-write word memory.
module tb_mem_access_unit;
  import mips_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_rdata;

  mem_access_unit #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: preloaded during reset, writes the addressed word while mem_wr is high.
  logic [31:0] mem [0:15];
  logic        preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
      mem[4] <= 32'h8899AABB;
    end else if (mem_wr) begin
      mem[mem_addr[5:2]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem_rd ? mem[mem_addr[5:2]] : 32'hDEADBEEF;

  logic both_seen = 1'b0;
  always @(negedge clk) if (mem_rd && mem_wr) both_seen <= 1'b1;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] wdat;
  } vec_t;

  vec_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] ob_rdata, ob_wdat, ob_maddr;
  logic        ob_err;
  int          ob_lat, ob_nrd, ob_nwr, ob_busy, ob_proto;

  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                              input int hold, input logic [31:0] rdata, input logic err,
                              input int lat, input int nrd, input int nwr, input logic [31:0] wdat);
    vec_t v;
    v.op = op; v.addr = addr; v.wdata = wdata; v.hold = hold; v.rdata = rdata;
    v.err = err; v.lat = lat; v.nrd = nrd; v.nwr = nwr; v.wdat = wdat;
    return v;
  endfunction

  // Drives one request, records what the DUT did, holds the response for `hold` cycles, then takes it.
  task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata, input int hold);
    ob_nrd = 0; ob_nwr = 0; ob_wdat = 32'h0; ob_maddr = 32'h0; ob_busy = 0; ob_proto = 0;
    @(negedge clk);
    if (req_ready !== 1'b1) ob_proto++;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    ob_lat = 1;
    while (1) begin
      if (mem_rd) begin ob_nrd++; ob_maddr = mem_addr; end
      if (mem_wr) begin ob_nwr++; ob_wdat = mem_wdata; ob_maddr = mem_addr; end
      if (req_ready) ob_busy++;
      if (resp_valid || ob_lat >= 20) break;
      @(posedge clk); #1;
      ob_lat++;
    end
    ob_rdata = resp_rdata;
    ob_err   = resp_err;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (resp_valid !== 1'b1 || resp_rdata !== ob_rdata || resp_err !== ob_err) ob_proto++;
      if (req_ready) ob_busy++;
      if (mem_rd || mem_wr) ob_proto++;
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) ob_proto++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({req_ready, resp_valid, resp_err, mem_rd, mem_wr} !== 5'b10000 || {resp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
      n_fail++;
      $display("FAIL reset_hold got rdy=%b vld=%b err=%b rd=%b wr=%b rdata=%h addr=%h wdata=%h exp 1 0 0 0 0 and zeros",
               req_ready, resp_valid, resp_err, mem_rd, mem_wr, resp_rdata, mem_addr, mem_wdata);
    end
    rst_n = 1'b1; preload = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({req_ready, resp_valid, mem_rd, mem_wr} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_release got rdy=%b vld=%b rd=%b wr=%b exp 1 0 0 0", req_ready, resp_valid, mem_rd, mem_wr);
    end
  endtask

  task automatic test_loads();
    vec_t v[$];
    vec_t e;
    v.push_back(mk(OP_LB,  32'h11, 32'h0, 0, 32'hFFFFFF99, 1'b0, 2, 1, 0, 32'h0));
    v.push_back(mk(OP_LBU, 32'h11, 32'h0, 0, 32'h00000099, 1'b0, 2, 1, 0, 32'h0));
    v.push_back(mk(OP_LB,  32'h13, 32'h0, 0, 32'hFFFFFFBB, 1'b0, 2, 1, 0, 32'h0));
    v.push_back(mk(OP_LH,  32'h12, 32'h0, 0, 32'hFFFFAABB, 1'b0, 2, 1, 0, 32'h0));
    v.push_back(mk(OP_LHU, 32'h10, 32'h0, 0, 32'h00008899, 1'b0, 2, 1, 0, 32'h0));
    v.push_back(mk(OP_LW,  32'h10, 32'h0, 0, 32'h8899AABB, 1'b0, 2, 1, 0, 32'h0));
    foreach (v[i]) begin
      exp_q.push_back(v[i]);
      run_req(v[i].op, v[i].addr, v[i].wdata, v[i].hold);
      e = exp_q.pop_front();
      n_tests++; if (ob_rdata !== e.rdata) begin n_fail++; $display("FAIL load_rdata op=%0d addr=%h got %h exp %h", e.op, e.addr, ob_rdata, e.rdata); end
      n_tests++; if (ob_err !== e.err) begin n_fail++; $display("FAIL load_err op=%0d addr=%h got %b exp %b", e.op, e.addr, ob_err, e.err); end
      n_tests++; if (ob_lat !== e.lat) begin n_fail++; $display("FAIL load_latency op=%0d addr=%h got %0d exp %0d", e.op, e.addr, ob_lat, e.lat); end
      n_tests++; if (ob_nrd !== e.nrd || ob_nwr !== e.nwr) begin n_fail++; $display("FAIL load_strobes op=%0d addr=%h got rd=%0d wr=%0d exp rd=%0d wr=%0d", e.op, e.addr, ob_nrd, ob_nwr, e.nrd, e.nwr); end
      n_tests++; if (ob_maddr !== {e.addr[31:2], 2'b00}) begin n_fail++; $display("FAIL load_mem_addr op=%0d got %h exp %h", e.op, ob_maddr, {e.addr[31:2], 2'b00}); end
      n_tests++; if (ob_busy !== 0 || ob_proto !== 0) begin n_fail++; $display("FAIL load_handshake op=%0d got busy=%0d proto=%0d exp 0 0", e.op, ob_busy, ob_proto); end
    end
  endtask

  task automatic test_sub_word_store();
    vec_t v[$];
    vec_t e;
    v.push_back(mk(OP_SB, 32'h13, 32'h123456CC, 0, 32'h0, 1'b0, 3, 1, 1, 32'h8899AACC));
    v.push_back(mk(OP_LW, 32'h10, 32'h0,        0, 32'h8899AACC, 1'b0, 2, 1, 0, 32'h0));
    v.push_back(mk(OP_SH, 32'h12, 32'h1234BEEF, 0, 32'h0, 1'b0, 3, 1, 1, 32'h8899BEEF));
    v.push_back(mk(OP_LW, 32'h10, 32'h0,        0, 32'h8899BEEF, 1'b0, 2, 1, 0, 32'h0));
    foreach (v[i]) begin
      exp_q.push_back(v[i]);
      run_req(v[i].op, v[i].addr, v[i].wdata, v[i].hold);
      e = exp_q.pop_front();
      n_tests++; if (ob_rdata !== e.rdata || ob_err !== e.err) begin n_fail++; $display("FAIL rmw_resp op=%0d addr=%h got %h/%b exp %h/%b", e.op, e.addr, ob_rdata, ob_err, e.rdata, e.err); end
      n_tests++; if (ob_lat !== e.lat) begin n_fail++; $display("FAIL rmw_latency op=%0d got %0d exp %0d", e.op, ob_lat, e.lat); end
      n_tests++; if (ob_nrd !== e.nrd || ob_nwr !== e.nwr) begin n_fail++; $display("FAIL rmw_strobes op=%0d got rd=%0d wr=%0d exp rd=%0d wr=%0d", e.op, ob_nrd, ob_nwr, e.nrd, e.nwr); end
      if (e.nwr > 0) begin
        n_tests++; if (ob_wdat !== e.wdat) begin n_fail++; $display("FAIL rmw_wdata op=%0d got %h exp %h", e.op, ob_wdat, e.wdat); end
      end
      n_tests++; if (ob_busy !== 0 || ob_proto !== 0) begin n_fail++; $display("FAIL rmw_handshake op=%0d got busy=%0d proto=%0d exp 0 0", e.op, ob_busy, ob_proto); end
    end
  endtask

  task automatic test_misaligned();
    vec_t v[$];
    vec_t e;
    v.push_back(mk(OP_LW,  32'h12, 32'h0,        0, 32'h0, 1'b1, 1, 0, 0, 32'h0));
    v.push_back(mk(OP_SH,  32'h11, 32'h0000FFFF, 0, 32'h0, 1'b1, 1, 0, 0, 32'h0));
    v.push_back(mk(OP_LHU, 32'h13, 32'h0,        0, 32'h0, 1'b1, 1, 0, 0, 32'h0));
    v.push_back(mk(OP_SW,  32'h11, 32'hFFFFFFFF, 2, 32'h0, 1'b1, 1, 0, 0, 32'h0));
    v.push_back(mk(OP_LW,  32'h10, 32'h0,        0, 32'h8899BEEF, 1'b0, 2, 1, 0, 32'h0));
    foreach (v[i]) begin
      exp_q.push_back(v[i]);
      run_req(v[i].op, v[i].addr, v[i].wdata, v[i].hold);
      e = exp_q.pop_front();
      n_tests++; if (ob_err !== e.err || ob_rdata !== e.rdata) begin n_fail++; $display("FAIL misalign_resp op=%0d addr=%h got %h/%b exp %h/%b", e.op, e.addr, ob_rdata, ob_err, e.rdata, e.err); end
      n_tests++; if (ob_lat !== e.lat) begin n_fail++; $display("FAIL misalign_latency op=%0d addr=%h got %0d exp %0d", e.op, e.addr, ob_lat, e.lat); end
      n_tests++; if (ob_nrd !== e.nrd || ob_nwr !== e.nwr) begin n_fail++; $display("FAIL misalign_strobes op=%0d got rd=%0d wr=%0d exp rd=%0d wr=%0d", e.op, ob_nrd, ob_nwr, e.nrd, e.nwr); end
      n_tests++; if (ob_busy !== 0 || ob_proto !== 0) begin n_fail++; $display("FAIL misalign_handshake op=%0d got busy=%0d proto=%0d exp 0 0", e.op, ob_busy, ob_proto); end
    end
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    vec_t e;
    v.push_back(mk(OP_SW, 32'h10, 32'h12345678, 5, 32'h0, 1'b0, 2, 0, 1, 32'h12345678));
    v.push_back(mk(OP_LW, 32'h10, 32'h0,        0, 32'h12345678, 1'b0, 2, 1, 0, 32'h0));
    v.push_back(mk(OP_SW, 32'h10, 32'h8899AABB, 0, 32'h0, 1'b0, 2, 0, 1, 32'h8899AABB));
    foreach (v[i]) begin
      exp_q.push_back(v[i]);
      run_req(v[i].op, v[i].addr, v[i].wdata, v[i].hold);
      e = exp_q.pop_front();
      n_tests++; if (ob_rdata !== e.rdata || ob_err !== e.err) begin n_fail++; $display("FAIL b2b_resp op=%0d got %h/%b exp %h/%b", e.op, ob_rdata, ob_err, e.rdata, e.err); end
      n_tests++; if (ob_lat !== e.lat) begin n_fail++; $display("FAIL b2b_latency op=%0d got %0d exp %0d", e.op, ob_lat, e.lat); end
      n_tests++; if (ob_nrd !== e.nrd || ob_nwr !== e.nwr) begin n_fail++; $display("FAIL b2b_strobes op=%0d got rd=%0d wr=%0d exp rd=%0d wr=%0d", e.op, ob_nrd, ob_nwr, e.nrd, e.nwr); end
      if (e.nwr > 0) begin
        n_tests++; if (ob_wdat !== e.wdat || ob_maddr !== e.addr) begin n_fail++; $display("FAIL b2b_write got %h@%h exp %h@%h", ob_wdat, ob_maddr, e.wdat, e.addr); end
      end
      n_tests++; if (ob_busy !== 0 || ob_proto !== 0) begin n_fail++; $display("FAIL b2b_hold op=%0d got busy=%0d proto=%0d exp 0 0", e.op, ob_busy, ob_proto); end
    end
  endtask

  task automatic test_reset_mid_rmw();
    vec_t e;
    int wr_cnt;
    wr_cnt = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_SH; req_addr = 32'h10; req_wdata = 32'h0000BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_tests++;
    if (mem_rd !== 1'b1 || mem_addr !== 32'h10) begin n_fail++; $display("FAIL rst_mid_in_rd got rd=%b addr=%h exp 1 00000010", mem_rd, mem_addr); end
    #1; rst_n = 1'b0; #1;
    n_tests++;
    if ({req_ready, resp_valid, resp_err, mem_rd, mem_wr} !== 5'b10000 || {resp_rdata, mem_addr, mem_wdata} !== 96'h0) begin
      n_fail++;
      $display("FAIL rst_mid_async got rdy=%b vld=%b err=%b rd=%b wr=%b rdata=%h addr=%h wdata=%h exp 1 0 0 0 0 and zeros",
               req_ready, resp_valid, resp_err, mem_rd, mem_wr, resp_rdata, mem_addr, mem_wdata);
    end
    repeat (2) begin @(posedge clk); #1; if (mem_wr) wr_cnt++; end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; if (mem_wr) wr_cnt++; end
    n_tests++;
    if (wr_cnt !== 0) begin n_fail++; $display("FAIL rst_mid_no_write got %0d writes exp 0", wr_cnt); end
    exp_q.push_back(mk(OP_LW, 32'h10, 32'h0, 0, 32'h8899AABB, 1'b0, 2, 1, 0, 32'h0));
    run_req(OP_LW, 32'h10, 32'h0, 0);
    e = exp_q.pop_front();
    n_tests++;
    if (ob_rdata !== e.rdata || ob_lat !== e.lat) begin n_fail++; $display("FAIL rst_mid_memory got %h lat %0d exp %h lat %0d", ob_rdata, ob_lat, e.rdata, e.lat); end
    n_tests++;
    if (both_seen !== 1'b0) begin n_fail++; $display("FAIL rd_wr_overlap got %b exp 0", both_seen); end
  endtask

  initial begin
    rst_n = 1'b1; preload = 1'b1;
    req_valid = 1'b0; req_op = 3'd0; req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_loads();
    test_sub_word_store();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_rmw();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
